// File: rtl/dram_buffer_pkg.sv
// Shared constants and helpers for the DRAM controller staging FIFO.
// Holds the default geometry, the read-mode encodings and the pointer-width helper.
package dram_buffer_pkg;

    localparam int DRAM_BUF_DATA_W = 8;
    localparam int DRAM_BUF_DEPTH  = 16;

    localparam int FIFO_STD  = 0;
    localparam int FIFO_FWFT = 1;

    // Pointers carry one extra wrap bit above the RAM address.
    function automatic int ptr_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/dram_buffer_mem.sv
// Simple dual-port storage for the staging FIFO: one write port and one
// registered read port, with no reset on the array or the read register.
module dram_buffer_mem
    import dram_buffer_pkg::*;
#(
    parameter int  DATA_W = DRAM_BUF_DATA_W,
    parameter int  DEPTH  = DRAM_BUF_DEPTH,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic              re_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rdata_q;

    // A read and a write to the same slot return the old contents.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
        if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/dram_fifo_buffer.sv
// Staging FIFO between the command front-end and the DRAM datapath, with
// occupancy count, threshold flags, sticky error flags and optional FWFT reads.
module dram_fifo_buffer
    import dram_buffer_pkg::*;
#(
    parameter int  DATA_W    = DRAM_BUF_DATA_W,
    parameter int  DEPTH     = DRAM_BUF_DEPTH,
    parameter int  AF_THRESH = DEPTH - 2,
    parameter int  AE_THRESH = 2,
    parameter int  FWFT      = FIFO_STD,
    localparam int ADDR_W    = $clog2(DEPTH),
    localparam int PTR_W     = ptr_width(DEPTH)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] datain,
    input  logic              rd_en,
    output logic [DATA_W-1:0] dataout,
    output logic              valid_out,
    output logic              empty_flag,
    output logic              full_flag,
    output logic              almost_full,
    output logic              almost_empty,
    output logic [PTR_W-1:0]  count,
    output logic              overflow,
    output logic              underflow,
    input  logic              clr_err
);

    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  ram_cnt;
    logic              empty_q, full_q, af_q, ae_q;
    logic              valid_q, valid_d;
    logic              hold_q, hold_d;
    logic              seen_q, seen_d;
    logic              ovf_q, ovf_d;
    logic              udf_q, udf_d;
    logic              rd_acc, wr_acc, ram_re, rd_adv;
    logic [DATA_W-1:0] ram_rdata;

    dram_buffer_mem #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH)
    ) u_mem (
        .clk     (clk),
        .we_i    (wr_acc),
        .waddr_i (wr_ptr_q[ADDR_W-1:0]),
        .wdata_i (datain),
        .re_i    (ram_re),
        .raddr_i (rd_ptr_q[ADDR_W-1:0]),
        .rdata_o (ram_rdata)
    );

    // In FWFT mode the RAM read register doubles as the head-word holding
    // register; hold_q marks it occupied and it is included in count.
    always_comb begin
        rd_acc  = rd_en && !empty_q;
        wr_acc  = wr_en && (!full_q || rd_acc);
        ram_cnt = wr_ptr_q - rd_ptr_q;
        ram_re  = 1'b0;
        rd_adv  = 1'b0;
        hold_d  = hold_q;

        if (FWFT == FIFO_FWFT) begin
            if ((ram_cnt != '0) && (hold_q ? rd_acc : !rd_acc)) begin
                ram_re = 1'b1;
                rd_adv = 1'b1;
                hold_d = 1'b1;
            end else if (rd_acc) begin
                rd_adv = !hold_q;
                hold_d = 1'b0;
            end
        end else begin
            ram_re = rd_acc;
            rd_adv = rd_acc;
            hold_d = 1'b0;
        end

        wr_ptr_d = wr_ptr_q + PTR_W'(wr_acc);
        rd_ptr_d = rd_ptr_q + PTR_W'(rd_adv);
        count_d  = count_q + PTR_W'(wr_acc) - PTR_W'(rd_acc);
        valid_d  = rd_acc;
        seen_d   = seen_q | ram_re;

        ovf_d = ovf_q;
        if (wr_en && full_q && !rd_acc) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end

        udf_d = udf_q;
        if (rd_en && empty_q) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            empty_q  <= 1'b1;
            full_q   <= 1'b0;
            af_q     <= 1'b0;
            ae_q     <= 1'b1;
            valid_q  <= 1'b0;
            hold_q   <= 1'b0;
            seen_q   <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            empty_q  <= (count_d == '0);
            full_q   <= (count_d == PTR_W'(DEPTH));
            af_q     <= (count_d >= PTR_W'(AF_THRESH));
            ae_q     <= (count_d <= PTR_W'(AE_THRESH));
            valid_q  <= valid_d;
            hold_q   <= hold_d;
            seen_q   <= seen_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    // The read register is not reset, so dataout reads zero until its first load.
    assign dataout      = seen_q ? ram_rdata : '0;
    assign valid_out    = (FWFT == FIFO_FWFT) ? !empty_q : valid_q;
    assign empty_flag   = empty_q;
    assign full_flag    = full_q;
    assign almost_full  = af_q;
    assign almost_empty = ae_q;
    assign count        = count_q;
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule

// File: tb/tb_dram_fifo_buffer.sv
// Self-checking bench for dram_fifo_buffer: a standard-mode instance checked
// against a queue scoreboard, plus an FWFT-mode instance for head presentation.
module tb_dram_fifo_buffer;

    localparam int DEPTH = 16;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic       wr_en = 1'b0, rd_en = 1'b0, clr_err = 1'b0;
    logic [7:0] datain = '0, dataout;
    logic       valid_out, empty_flag, full_flag, almost_full, almost_empty;
    logic       overflow, underflow;
    logic [4:0] count;

    logic       f_wr = 1'b0, f_rd = 1'b0, f_clr = 1'b0;
    logic [7:0] f_din = '0, f_dout;
    logic       f_valid, f_empty, f_full, f_af, f_ae, f_ovf, f_udf;
    logic [4:0] f_count;

    dram_fifo_buffer #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(0)) u_std (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .datain(datain), .rd_en(rd_en),
        .dataout(dataout), .valid_out(valid_out), .empty_flag(empty_flag),
        .full_flag(full_flag), .almost_full(almost_full), .almost_empty(almost_empty),
        .count(count), .overflow(overflow), .underflow(underflow), .clr_err(clr_err)
    );

    dram_fifo_buffer #(.DATA_W(8), .DEPTH(DEPTH), .FWFT(1)) u_fwft (
        .clk(clk), .rst_n(rst_n), .wr_en(f_wr), .datain(f_din), .rd_en(f_rd),
        .dataout(f_dout), .valid_out(f_valid), .empty_flag(f_empty),
        .full_flag(f_full), .almost_full(f_af), .almost_empty(f_ae),
        .count(f_count), .overflow(f_ovf), .underflow(f_udf), .clr_err(f_clr)
    );

    int         checks = 0;
    int         errors = 0;
    int         m_cnt = 0;
    int         rd_seen = 0;
    logic [7:0] sb[$];
    logic [7:0] sb_exp;

    // Every valid_out pulse consumes the oldest accepted write.
    always @(negedge clk) begin
        if (rst_n && valid_out) begin
            rd_seen++;
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("[TB] FAIL sb_extra_valid: dataout=%h with no word expected", dataout);
            end else begin
                sb_exp = sb.pop_front();
                if (dataout !== sb_exp) begin
                    errors++;
                    $display("[TB] FAIL sb_data: dataout=%h required %h", dataout, sb_exp);
                end
            end
        end
    end

    task automatic cyc(input logic w, input logic [7:0] d, input logic r, input logic clr);
        logic m_rd, m_wr;
        wr_en   = w;
        datain  = d;
        rd_en   = r;
        clr_err = clr;
        m_rd = r && (m_cnt > 0);
        m_wr = w && ((m_cnt < DEPTH) || m_rd);
        if (m_wr) sb.push_back(d);
        @(posedge clk);
        #1;
        m_cnt   = m_cnt + int'(m_wr) - int'(m_rd);
        wr_en   = 1'b0;
        rd_en   = 1'b0;
        clr_err = 1'b0;
    endtask

    task automatic test_reset;
        #12;
        checks++;
        if ({count, empty_flag, almost_empty, full_flag, almost_full, valid_out, overflow, underflow} !== {5'd0, 7'b1100000}) begin
            errors++;
            $display("[TB] FAIL reset_flags: cnt=%0d e=%b ae=%b f=%b af=%b v=%b ov=%b un=%b required 0 1 1 0 0 0 0 0",
                     count, empty_flag, almost_empty, full_flag, almost_full, valid_out, overflow, underflow);
        end
        checks++;
        if (dataout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL reset_dataout: got %h required 00", dataout);
        end
        checks++;
        if ({f_dout, f_valid, f_empty} !== {8'h00, 1'b0, 1'b1}) begin
            errors++;
            $display("[TB] FAIL reset_fwft: dout=%h v=%b e=%b required 00 0 1", f_dout, f_valid, f_empty);
        end
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_basic;
        int seen0;
        seen0 = rd_seen;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(i), 1'b0, 1'b0);
        checks++;
        if ({count, empty_flag, almost_empty} !== {5'd5, 2'b00}) begin
            errors++;
            $display("[TB] FAIL basic_fill: cnt=%0d e=%b ae=%b required 5 0 0", count, empty_flag, almost_empty);
        end
        for (int i = 0; i < 5; i++) begin
            cyc(1'b0, 8'h00, 1'b1, 1'b0);
            checks++;
            if (count !== 5'(m_cnt)) begin
                errors++;
                $display("[TB] FAIL basic_count: got %0d required %0d", count, m_cnt);
            end
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ((rd_seen - seen0 != 5) || (empty_flag !== 1'b1) || (sb.size() != 0)) begin
            errors++;
            $display("[TB] FAIL basic_drain: reads=%0d empty=%b left=%0d required 5 1 0",
                     rd_seen - seen0, empty_flag, sb.size());
        end
    endtask

    task automatic test_fill;
        int seen0;
        for (int i = 0; i < DEPTH; i++) begin
            cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0);
            checks++;
            if ((count !== 5'(m_cnt)) || (almost_full !== (m_cnt >= 14)) || (full_flag !== (m_cnt == 16))) begin
                errors++;
                $display("[TB] FAIL fill_flags: cnt=%0d af=%b full=%b required cnt %0d", count, almost_full, full_flag, m_cnt);
            end
        end
        cyc(1'b1, 8'hEE, 1'b0, 1'b0);
        checks++;
        if ({overflow, full_flag, count} !== {2'b11, 5'd16}) begin
            errors++;
            $display("[TB] FAIL fill_overflow: ov=%b full=%b cnt=%0d required 1 1 16", overflow, full_flag, count);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (overflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL fill_clr: overflow=%b required 0", overflow);
        end
        seen0 = rd_seen;
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ((rd_seen - seen0 != 16) || (empty_flag !== 1'b1) || (underflow !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL fill_drain: reads=%0d empty=%b un=%b required 16 1 0", rd_seen - seen0, empty_flag, underflow);
        end
    endtask

    task automatic test_back_to_back;
        int seen0;
        for (int i = 0; i < DEPTH; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0);
        seen0 = rd_seen;
        for (int i = 0; i < 3; i++) begin
            cyc(1'b1, 8'hAA, 1'b1, 1'b0);
            checks++;
            if ({count, overflow, full_flag} !== {5'd16, 2'b01}) begin
                errors++;
                $display("[TB] FAIL b2b_full: cnt=%0d ov=%b full=%b required 16 0 1", count, overflow, full_flag);
            end
        end
        for (int i = 0; i < DEPTH; i++) cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b0);
        checks++;
        if ((rd_seen - seen0 != 19) || (sb.size() != 0) || (count !== 5'd0)) begin
            errors++;
            $display("[TB] FAIL b2b_drain: reads=%0d left=%0d cnt=%0d required 19 0 0", rd_seen - seen0, sb.size(), count);
        end
    endtask

    task automatic test_underflow;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({underflow, count, valid_out} !== {1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL udf_set: un=%b cnt=%0d v=%b required 1 0 0", underflow, count, valid_out);
        end
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if (underflow !== 1'b0) begin
            errors++;
            $display("[TB] FAIL udf_clr: underflow=%b required 0", underflow);
        end
        cyc(1'b1, 8'h55, 1'b1, 1'b0);
        checks++;
        if ({count, underflow, valid_out, empty_flag} !== {5'd1, 3'b100}) begin
            errors++;
            $display("[TB] FAIL udf_wr_rd_empty: cnt=%0d un=%b v=%b e=%b required 1 1 0 0", count, underflow, valid_out, empty_flag);
        end
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        cyc(1'b0, 8'h00, 1'b0, 1'b1);
        checks++;
        if ((sb.size() != 0) || (underflow !== 1'b0)) begin
            errors++;
            $display("[TB] FAIL udf_drain: left=%0d un=%b required 0 0", sb.size(), underflow);
        end
    endtask

    task automatic test_fwft;
        logic [7:0] words [3];
        words[0] = 8'h41;
        words[1] = 8'h42;
        words[2] = 8'h43;
        f_wr = 1'b1; f_din = 8'h33;
        @(posedge clk); #1;
        f_wr = 1'b0;
        @(posedge clk); #1;
        checks++;
        if ({f_dout, f_valid, f_count} !== {8'h33, 1'b1, 5'd1}) begin
            errors++;
            $display("[TB] FAIL fwft_present: dout=%h v=%b cnt=%0d required 33 1 1", f_dout, f_valid, f_count);
        end
        f_rd = 1'b1;
        @(posedge clk); #1;
        f_rd = 1'b0;
        checks++;
        if ({f_valid, f_empty} !== 2'b01) begin
            errors++;
            $display("[TB] FAIL fwft_pop: v=%b e=%b required 0 1", f_valid, f_empty);
        end
        for (int i = 0; i < 3; i++) begin
            f_wr = 1'b1; f_din = words[i];
            @(posedge clk); #1;
        end
        f_wr = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({f_dout, f_valid, f_count} !== {words[i], 1'b1, 5'(3 - i)}) begin
                errors++;
                $display("[TB] FAIL fwft_b2b: dout=%h v=%b cnt=%0d required %h 1 %0d", f_dout, f_valid, f_count, words[i], 3 - i);
            end
            f_rd = 1'b1;
            @(posedge clk); #1;
            f_rd = 1'b0;
        end
        checks++;
        if ({f_valid, f_empty, f_udf} !== 3'b010) begin
            errors++;
            $display("[TB] FAIL fwft_end: v=%b e=%b un=%b required 0 1 0", f_valid, f_empty, f_udf);
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h60 + i), 1'b0, 1'b0);
        wr_en = 1'b1; datain = 8'h65;
        #2 rst_n = 1'b0;
        #1;
        wr_en = 1'b0;
        checks++;
        if ({count, empty_flag, almost_empty, full_flag, almost_full, valid_out, overflow, underflow} !== {5'd0, 7'b1100000}) begin
            errors++;
            $display("[TB] FAIL midrst_flags: cnt=%0d e=%b ae=%b f=%b af=%b v=%b required 0 1 1 0 0 0",
                     count, empty_flag, almost_empty, full_flag, almost_full, valid_out);
        end
        checks++;
        if (dataout !== 8'h00) begin
            errors++;
            $display("[TB] FAIL midrst_dataout: got %h required 00", dataout);
        end
        sb.delete();
        m_cnt = 0;
        @(negedge clk) rst_n = 1'b1;
        cyc(1'b0, 8'h00, 1'b1, 1'b0);
        checks++;
        if ({underflow, count, valid_out} !== {1'b1, 5'd0, 1'b0}) begin
            errors++;
            $display("[TB] FAIL midrst_udf: un=%b cnt=%0d v=%b required 1 0 0", underflow, count, valid_out);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_fill();
        test_back_to_back();
        test_underflow();
        test_fwft();
        test_reset_mid();
        repeat (2) @(posedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
